alu_arbiter: RTL and testbench

- Shares one 16-bit combinational ALU between two requesters, for example a decode/execute path and a multi-cycle address or branch helper.
- Each requester issues an operation with a valid/ready handshake. The block arbitrates between them, drives the shared ALU, and registers the result with its flags.
- The registered result is returned to the winning requester on its own valid/ready response channel.

---
 rtl/alu_arbiter_pkg.sv | 35 +++
 rtl/alu_arbiter_alu.sv | 50 +++++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states,
// requester index type and the 2-way grant picker.
package alu_arbiter_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned NREQ = 2;
  localparam int unsigned IDXW = 1;

  typedef logic [IDXW-1:0] idx_t;

  localparam logic [2:0] OP_RLL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // With both requests pending, round-robin favours the one not served last.
  function automatic idx_t rr_pick(input logic [NREQ-1:0] valid,
                                   input idx_t last,
                                   input logic rr_en);
    idx_t win;
    if (valid == 2'b11) win = rr_en ? ~last : idx_t'(0);
    else                win = valid[1] ? idx_t'(1) : idx_t'(0);
    return win;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 16-bit combinational ALU: shift group, add, or, xor, and, with
// operand inversion and {Z,N,P} flags derived from the result.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          cin_i,
  input  logic [2:0]    op_i,
  input  logic          inva_i,
  input  logic          invb_i,
  input  logic          sign_i,
  output logic [DW-1:0] out_o,
  output logic          ofl_o,
  output logic [2:0]    flags_o
);

  logic [DW-1:0] a, b;
  logic [DW:0]   sum;
  logic [3:0]    shamt;
  logic          z, n;

  always_comb begin
    a     = inva_i ? ~a_i : a_i;
    b     = invb_i ? ~b_i : b_i;
    shamt = b[3:0];
    sum   = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin_i};
    out_o = '0;
    ofl_o = 1'b0;
    case (op_i)
      OP_RLL: out_o = (a << shamt) | (a >> (5'd16 - {1'b0, shamt}));
      OP_SLL: out_o = a << shamt;
      OP_SRA: out_o = $signed(a) >>> shamt;
      OP_SRL: out_o = a >> shamt;
      OP_ADD: begin
        out_o = sum[DW-1:0];
        // Signed mode flags two's-complement overflow, unsigned mode the carry out.
        ofl_o = sign_i ? ((a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]))
                       : sum[DW];
      end
      OP_OR:  out_o = a | b;
      OP_XOR: out_o = a ^ b;
      OP_AND: out_o = a & b;
    endcase
    z       = (out_o == '0);
    n       = out_o[DW-1];
    flags_o = {z, n, ~(z ^ n)};
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two valid/ready requesters onto one shared ALU and returns the
// registered result on the winner's response channel; 1 op/cycle when drained.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_cin,
  input  logic [5:0]  req_op,
  input  logic [1:0]  req_inva,
  input  logic [1:0]  req_invb,
  input  logic [1:0]  req_sign,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_out,
  output logic        rsp_ofl,
  output logic [2:0]  rsp_flags,
  output logic        busy
);

  state_e        state_q, state_d;
  idx_t          owner_q, owner_d;
  idx_t          last_q, last_d;
  logic [DW-1:0] out_q, out_d;
  logic          ofl_q, ofl_d;
  logic [2:0]    flags_q, flags_d;

  logic          free, gnt_any;
  idx_t          gnt_idx, sel;
  logic [DW-1:0] alu_out;
  logic          alu_ofl;
  logic [2:0]    alu_flags;

  // A full result register frees up in the same cycle its owner drains it.
  always_comb begin
    free      = (state_q == IDLE) || ((state_q == RESP) && rsp_ready[owner_q]);
    gnt_any   = free && (req_valid != 2'b00) && !rst;
    gnt_idx   = rr_pick(req_valid, last_q, RR_EN);
    req_ready = gnt_any ? (2'b01 << gnt_idx) : 2'b00;
    sel       = gnt_any ? gnt_idx : idx_t'(0);
  end

  alu u_alu (
    .a_i     (sel ? req_a[31:16] : req_a[15:0]),
    .b_i     (sel ? req_b[31:16] : req_b[15:0]),
    .cin_i   (req_cin[sel]),
    .op_i    (sel ? req_op[5:3] : req_op[2:0]),
    .inva_i  (req_inva[sel]),
    .invb_i  (req_invb[sel]),
    .sign_i  (req_sign[sel]),
    .out_o   (alu_out),
    .ofl_o   (alu_ofl),
    .flags_o (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= idx_t'(1);
      out_q   <= '0;
      ofl_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      out_q   <= out_d;
      ofl_q   <= ofl_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    out_d   = out_q;
    ofl_d   = ofl_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: if (gnt_any) state_d = RESP;
      RESP: if (rsp_ready[owner_q]) state_d = gnt_any ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
    if (gnt_any) begin
      owner_d = gnt_idx;
      last_d  = gnt_idx;
      out_d   = alu_out;
      ofl_d   = alu_ofl;
      flags_d = alu_flags;
    end
  end

  always_comb begin
    busy      = (state_q == RESP);
    rsp_valid = busy ? (2'b01 << owner_q) : 2'b00;
    rsp_out   = out_q;
    rsp_ofl   = ofl_q;
    rsp_flags = flags_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: the driver queues hand-computed results on every accept and
// a monitor checks them against the DUT whenever the owner consumes a result.
module tb_alu_arbiter;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [2:0]  op;
    logic        inva;
    logic        invb;
    logic        sign;
  } vec_t;

  typedef struct packed {
    logic        idx;
    logic [15:0] out;
    logic        ofl;
    logic [2:0]  flags;
  } exp_t;

  logic        clk, rst;
  logic [1:0]  req_valid, req_ready, fp_req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_cin, req_inva, req_invb, req_sign;
  logic [5:0]  req_op;
  logic [1:0]  rsp_valid, rsp_ready, fp_rsp_valid;
  logic [15:0] rsp_out, fp_rsp_out;
  logic        rsp_ofl, busy, fp_rsp_ofl, fp_busy;
  logic [2:0]  rsp_flags, fp_rsp_flags;

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t pv[2];
  exp_t pe[2];
  logic pr_rst;

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op),
    .req_inva(req_inva), .req_invb(req_invb), .req_sign(req_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_ofl(rsp_ofl), .rsp_flags(rsp_flags), .busy(busy)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op),
    .req_inva(req_inva), .req_invb(req_invb), .req_sign(req_sign),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_out(fp_rsp_out),
    .rsp_ofl(fp_rsp_ofl), .rsp_flags(fp_rsp_flags), .busy(fp_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              input logic [2:0] op, input logic inva, input logic invb,
                              input logic sign);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.op = op; v.inva = inva; v.invb = invb; v.sign = sign;
    return v;
  endfunction

  function automatic exp_t ex(input logic idx, input logic [15:0] out, input logic ofl,
                              input logic [2:0] flags);
    exp_t e;
    e.idx = idx; e.out = out; e.ofl = ofl; e.flags = flags;
    return e;
  endfunction

  // One cycle: apply pending vectors just after the edge, check the grant
  // mid-cycle and queue the expected result for whichever requester won.
  task automatic go(input logic [1:0] rv, input logic [1:0] rr, input logic [1:0] erdy);
    @(posedge clk);
    #1;
    rst       = pr_rst;
    req_valid = rv;
    rsp_ready = rr;
    for (int unsigned i = 0; i < 2; i++) begin
      req_a[i*16 +: 16] = pv[i].a;
      req_b[i*16 +: 16] = pv[i].b;
      req_op[i*3 +: 3]  = pv[i].op;
      req_cin[i]        = pv[i].cin;
      req_inva[i]       = pv[i].inva;
      req_invb[i]       = pv[i].invb;
      req_sign[i]       = pv[i].sign;
    end
    @(negedge clk);
    chk("req_ready", {30'd0, req_ready}, {30'd0, erdy});
    for (int unsigned i = 0; i < 2; i++)
      if (req_ready[i]) sb.push_back(pe[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int unsigned i = 0; i < 2; i++) begin
        if (!rst && rsp_valid[i] && rsp_ready[i]) begin
          if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_owner", i, {31'd0, e.idx});
            chk("rsp_out", {16'd0, rsp_out}, {16'd0, e.out});
            chk("rsp_ofl", {31'd0, rsp_ofl}, {31'd0, e.ofl});
            chk("rsp_flags", {29'd0, rsp_flags}, {29'd0, e.flags});
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pr_rst = 1'b1;
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    req_cin = '0; req_op = '0; req_inva = '0; req_invb = '0; req_sign = '0;
    pv[0] = '0; pv[1] = '0; pe[0] = '0; pe[1] = '0;

    go(2'b11, 2'b00, 2'b00);
    go(2'b11, 2'b00, 2'b00);
    pr_rst = 1'b0;
    go(2'b00, 2'b00, 2'b00);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_out", {16'd0, rsp_out}, 32'd0);
    chk("rst_ofl_flags", {28'd0, rsp_ofl, rsp_flags}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single request, one-cycle latency.
    pv[0] = mk(16'h0003, 16'h0004, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
    pe[0] = ex(1'b0, 16'h0007, 1'b0, 3'b001);
    go(2'b01, 2'b00, 2'b01);
    go(2'b00, 2'b01, 2'b00);
    chk("lat_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    go(2'b00, 2'b00, 2'b00);
    chk("drained_valid", {30'd0, rsp_valid}, 32'd0);
    chk("drained_busy", {31'd0, busy}, 32'd0);

    // Contention: round-robin alternates, fixed priority always picks 0.
    pv[0] = mk(16'h0010, 16'h0020, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1);
    pe[0] = ex(1'b0, 16'h0030, 1'b0, 3'b001);
    pv[1] = mk(16'h7FFF, 16'h0001, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1);
    pe[1] = ex(1'b1, 16'h8000, 1'b1, 3'b010);
    for (int k = 0; k < 4; k++) begin
      go(2'b11, 2'b11, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("fp_req_ready", {30'd0, fp_req_ready}, 32'd1);
    end
    go(2'b00, 2'b11, 2'b00);
    go(2'b00, 2'b00, 2'b00);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Back-to-back requester 0 operations across the opcode set.
    pv[0] = mk(16'h0001, 16'h0004, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    pe[0] = ex(1'b0, 16'h0010, 1'b0, 3'b001);
    go(2'b01, 2'b01, 2'b01);
    pv[0] = mk(16'h0005, 16'h0007, 1'b1, 3'b100, 1'b0, 1'b1, 1'b1);
    pe[0] = ex(1'b0, 16'hFFFE, 1'b0, 3'b010);
    go(2'b01, 2'b01, 2'b01);
    pv[0] = mk(16'hFFFF, 16'h0001, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
    pe[0] = ex(1'b0, 16'h0000, 1'b1, 3'b100);
    go(2'b01, 2'b01, 2'b01);
    pv[0] = mk(16'h8000, 16'h0003, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
    pe[0] = ex(1'b0, 16'hF000, 1'b0, 3'b010);
    go(2'b01, 2'b01, 2'b01);
    pv[0] = mk(16'h8001, 16'h0001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    pe[0] = ex(1'b0, 16'h0003, 1'b0, 3'b001);
    go(2'b01, 2'b01, 2'b01);
    pv[0] = mk(16'h8000, 16'h000F, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
    pe[0] = ex(1'b0, 16'h0001, 1'b0, 3'b001);
    go(2'b01, 2'b01, 2'b01);
    pv[0] = mk(16'hFFFF, 16'h0F00, 1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
    pe[0] = ex(1'b0, 16'h0F00, 1'b0, 3'b001);
    go(2'b01, 2'b01, 2'b01);
    go(2'b00, 2'b01, 2'b00);

    // Backpressure with requester 1 waiting behind a pending result.
    pv[0] = mk(16'hA5A5, 16'hA5A5, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0);
    pe[0] = ex(1'b0, 16'h0000, 1'b0, 3'b100);
    go(2'b01, 2'b00, 2'b01);
    pv[1] = mk(16'hFFFF, 16'h8001, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
    pe[1] = ex(1'b1, 16'h8001, 1'b0, 3'b010);
    for (int k = 0; k < 3; k++) begin
      go(2'b10, 2'b00, 2'b00);
      chk("bp_rsp_out", {16'd0, rsp_out}, 32'd0);
      chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    end
    go(2'b10, 2'b10, 2'b00);
    chk("nonowner_ignored", {30'd0, rsp_valid}, 32'd1);
    go(2'b10, 2'b01, 2'b10);
    go(2'b00, 2'b10, 2'b00);
    go(2'b00, 2'b00, 2'b00);

    // Reset while requester 1 holds a result.
    go(2'b10, 2'b00, 2'b10);
    go(2'b00, 2'b00, 2'b00);
    chk("pre_rst_valid", {30'd0, rsp_valid}, 32'd2);
    pr_rst = 1'b1;
    go(2'b11, 2'b00, 2'b00);
    sb.delete();
    pr_rst = 1'b0;
    pv[0] = mk(16'h0003, 16'h0004, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0);
    pe[0] = ex(1'b0, 16'h0007, 1'b0, 3'b001);
    go(2'b11, 2'b11, 2'b01);
    chk("post_rst_valid", {30'd0, rsp_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_out", {16'd0, rsp_out}, 32'd0);
    go(2'b00, 2'b11, 2'b00);
    go(2'b00, 2'b00, 2'b00);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
